// File: rtl/clk_freq_mon_pkg.sv
// Shared types and constants for the clock frequency monitor.
package clk_freq_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        PUBLISH = 2'd2
    } state_t;

    localparam int WIN_MIN   = 2;
    localparam int NCLK_DEF  = 4;
    localparam int CNT_W_DEF = 32;
    localparam int WIN_W_DEF = 32;
    localparam int UNL_W_DEF = 16;

endpackage

// File: rtl/clk_freq_chan.sv
// One monitored channel: synchronizers, saturating edge counter, range check,
// sticky alarm and saturating unlock counter. Optional: CLK_FREQ_MON_LOCK_ALARM_EN.
module clk_freq_chan #(
    parameter int CNT_W = 32,
    parameter int UNL_W = 16
) (
    input  logic             clk_ref,
    input  logic             aresetn,
    input  logic             clk_test_i,
    input  logic             locked_i,
    input  logic             cnt_zero_i,
    input  logic             cnt_run_i,
    input  logic             publish_i,
    input  logic [CNT_W-1:0] min_cnt_i,
    input  logic [CNT_W-1:0] max_cnt_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] rate_o,
    output logic             in_range_o,
    output logic             alarm_o,
    output logic [UNL_W-1:0] unlocks_o
);

    logic [2:0]       test_sync_q;
    logic             test_prev_q;
    logic [2:0]       lock_sync_q;
    logic             lock_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] rate_q;
    logic             in_range_q;
    logic             alarm_q, alarm_d;
    logic [UNL_W-1:0] unl_q, unl_d;
    logic             rise, fall, out_of_range, alarm_set;

    assign rise         = test_sync_q[2] & ~test_prev_q;
    assign fall         = ~lock_sync_q[2] & lock_prev_q;
    assign out_of_range = (cnt_q < min_cnt_i) || (cnt_q > max_cnt_i);

`ifdef CLK_FREQ_MON_LOCK_ALARM_EN
    assign alarm_set = (publish_i & out_of_range) | fall;
`else
    assign alarm_set = publish_i & out_of_range;
`endif

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_zero_i)
            cnt_d = '0;
        else if (publish_i)
            cnt_d = CNT_W'(rise);  // an edge in the publish cycle belongs to the next window
        else if (cnt_run_i && rise && !(&cnt_q))
            cnt_d = cnt_q + CNT_W'(1);

        // a set in the same cycle as clr wins
        alarm_d = alarm_set | (alarm_q & ~clr_i);

        unl_d = unl_q;
        if (clr_i)
            unl_d = UNL_W'(fall);
        else if (fall && !(&unl_q))
            unl_d = unl_q + UNL_W'(1);
    end

    always_ff @(posedge clk_ref or negedge aresetn) begin
        if (!aresetn) begin
            test_sync_q <= '0;
            test_prev_q <= 1'b0;
            lock_sync_q <= '0;
            lock_prev_q <= 1'b0;
            cnt_q       <= '0;
            rate_q      <= '0;
            in_range_q  <= 1'b1;
            alarm_q     <= 1'b0;
            unl_q       <= '0;
        end else begin
            test_sync_q <= {test_sync_q[1:0], clk_test_i};
            test_prev_q <= test_sync_q[2];
            lock_sync_q <= {lock_sync_q[1:0], locked_i};
            lock_prev_q <= lock_sync_q[2];
            cnt_q       <= cnt_d;
            alarm_q     <= alarm_d;
            unl_q       <= unl_d;
            if (publish_i) begin
                rate_q     <= cnt_q;
                in_range_q <= ~out_of_range;
            end
        end
    end

    assign rate_o     = rate_q;
    assign in_range_o = in_range_q;
    assign alarm_o    = alarm_q;
    assign unlocks_o  = unl_q;

endmodule

// File: rtl/clk_freq_mon.sv
// Multi-channel clock frequency monitor: shared window FSM, per-channel counters.
// Define CLK_FREQ_MON_LOCK_ALARM_EN to also raise alarm on a lock loss.
module clk_freq_mon
    import clk_freq_mon_pkg::*;
#(
    parameter int NCLK  = NCLK_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int WIN_W = WIN_W_DEF,
    parameter int UNL_W = UNL_W_DEF
) (
    input  logic                  clk_ref,
    input  logic                  aresetn,
    input  logic [NCLK-1:0]       clk_test,
    input  logic [NCLK-1:0]       locked,
    input  logic                  enable,
    input  logic [WIN_W-1:0]      window,
    input  logic [NCLK*CNT_W-1:0] min_cnt,
    input  logic [NCLK*CNT_W-1:0] max_cnt,
    input  logic [NCLK-1:0]       clr,
    output logic [NCLK*CNT_W-1:0] rate,
    output logic                  rate_valid,
    output logic [NCLK-1:0]       in_range,
    output logic [NCLK-1:0]       alarm,
    output logic [NCLK*UNL_W-1:0] unlocks,
    output logic                  irq
);

    state_t           state_q;
    logic [WIN_W-1:0] win_cnt_q;
    logic             rate_valid_q;
    logic [WIN_W-1:0] win_lat;
    logic             cnt_zero, cnt_run, publish;

    assign win_lat = (window < WIN_W'(WIN_MIN)) ? WIN_W'(WIN_MIN) : window;

    // The publish cycle counts as the last cycle of the window, so the
    // counter leaves MEASURE while decrementing from 2 to 1.
    always_ff @(posedge clk_ref or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            win_cnt_q    <= '0;
            rate_valid_q <= 1'b0;
        end else begin
            rate_valid_q <= (state_q == PUBLISH);
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        win_cnt_q <= win_lat;
                        state_q   <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (!enable) begin
                        state_q <= IDLE;
                    end else begin
                        win_cnt_q <= win_cnt_q - WIN_W'(1);
                        if (win_cnt_q <= WIN_W'(WIN_MIN))
                            state_q <= PUBLISH;
                    end
                end
                PUBLISH: begin
                    win_cnt_q <= win_lat;
                    state_q   <= enable ? MEASURE : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cnt_zero   = (state_q == IDLE) && enable;
    assign cnt_run    = (state_q == MEASURE);
    assign publish    = (state_q == PUBLISH);
    assign rate_valid = rate_valid_q;
    assign irq        = |alarm;

    for (genvar i = 0; i < NCLK; i++) begin : g_chan
        clk_freq_chan #(
            .CNT_W(CNT_W),
            .UNL_W(UNL_W)
        ) u_chan (
            .clk_ref    (clk_ref),
            .aresetn    (aresetn),
            .clk_test_i (clk_test[i]),
            .locked_i   (locked[i]),
            .cnt_zero_i (cnt_zero),
            .cnt_run_i  (cnt_run),
            .publish_i  (publish),
            .min_cnt_i  (min_cnt[i*CNT_W +: CNT_W]),
            .max_cnt_i  (max_cnt[i*CNT_W +: CNT_W]),
            .clr_i      (clr[i]),
            .rate_o     (rate[i*CNT_W +: CNT_W]),
            .in_range_o (in_range[i]),
            .alarm_o    (alarm[i]),
            .unlocks_o  (unlocks[i*UNL_W +: UNL_W])
        );
    end

endmodule

// File: tb/tb_clk_freq_mon.sv
// Directed bench for clk_freq_mon: 100 MHz reference, 10/20/25 MHz test clocks.
module tb_clk_freq_mon;
    import clk_freq_mon_pkg::*;

    logic         clk_ref = 1'b0;
    logic         aresetn;
    logic         t10 = 1'b0, t20 = 1'b0, t25 = 1'b0;
    logic [3:0]   clk_test;
    logic [3:0]   locked;
    logic         enable;
    logic [31:0]  window;
    logic [127:0] min_cnt, max_cnt;
    logic [3:0]   clr;
    logic [127:0] rate;
    logic         rate_valid;
    logic [3:0]   in_range, alarm;
    logic [63:0]  unlocks;
    logic         irq;

    logic [0:0]   test_s;
    logic [0:0]   locked_s = 1'b1;
    logic [0:0]   clr_s = 1'b0;
    logic [31:0]  window_s = 32'd100;
    logic [3:0]   min_s = 4'd0, max_s = 4'd15;
    logic [3:0]   rate_s;
    logic         rv_s, irq_s;
    logic [0:0]   ir_s, al_s;
    logic [15:0]  unl_s;

    int tests = 0;
    int fails = 0;

    assign clk_test = {t10, 1'b0, t20, t10};
    assign test_s   = t25;

    clk_freq_mon dut (
        .clk_ref(clk_ref), .aresetn(aresetn), .clk_test(clk_test), .locked(locked),
        .enable(enable), .window(window), .min_cnt(min_cnt), .max_cnt(max_cnt),
        .clr(clr), .rate(rate), .rate_valid(rate_valid), .in_range(in_range),
        .alarm(alarm), .unlocks(unlocks), .irq(irq)
    );

    clk_freq_mon #(.NCLK(1), .CNT_W(4)) dut_sat (
        .clk_ref(clk_ref), .aresetn(aresetn), .clk_test(test_s), .locked(locked_s),
        .enable(enable), .window(window_s), .min_cnt(min_s), .max_cnt(max_s),
        .clr(clr_s), .rate(rate_s), .rate_valid(rv_s), .in_range(ir_s),
        .alarm(al_s), .unlocks(unl_s), .irq(irq_s)
    );

    initial forever #5 clk_ref = ~clk_ref;
    initial begin #3; forever #50 t10 = ~t10; end
    initial begin #3; forever #25 t20 = ~t20; end
    initial begin #3; forever #20 t25 = ~t25; end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_rv(input int maxc, output int n);
        n = 0;
        do begin
            @(negedge clk_ref);
            n++;
        end while (!rate_valid && n < maxc);
        chk("rv_seen", rate_valid, 1'b1);
    endtask

    initial begin
        int           n;
        int           rvc;
        logic [127:0] saved;
        logic [7:0]   exp_rv;
        logic         exp_lock_alarm;

        aresetn = 1'b0;
        enable  = 1'b0;
        window  = 32'd1000;
        clr     = 4'b0;
        locked  = 4'hF;
        min_cnt = {32'd0, 32'd0, 32'd95, 32'd95};
        max_cnt = {32'd99, 32'd0, 32'd105, 32'd105};
        repeat (3) @(negedge clk_ref);
        chk("rst_rate", |rate, 1'b0);
        chk("rst_rv", rate_valid, 1'b0);
        chk("rst_in_range", in_range, 4'hF);
        chk("rst_alarm", alarm, 4'h0);
        chk("rst_irq", irq, 1'b0);
        chk("rst_unlocks", |unlocks, 1'b0);

        aresetn = 1'b1;
        @(negedge clk_ref);
        enable = 1'b1;
        wait_rv(1100, n);
        chk("first_latency", n, 1001);
        chk("first_rate0_pm1", (rate[31:0] >= 99 && rate[31:0] <= 100), 1'b1);

        wait_rv(1100, n);
        chk("period", n, 1000);
        chk("rate0", rate[31:0], 100);
        chk("rate1", rate[63:32], 200);
        chk("rate2", rate[95:64], 0);
        chk("rate3", rate[127:96], 100);
        chk("in_range", in_range, 4'b0101);
        chk("alarm", alarm, 4'b1010);
        chk("irq", irq, 1'b1);
        chk("sat_rate", rate_s, 4'd15);
        chk("sat_in_range", ir_s, 1'b1);
        chk("sat_alarm", al_s, 1'b0);
        chk("sat_irq", irq_s, 1'b0);
        chk("sat_unlocks", unl_s, 0);

        clr = 4'b0010;
        @(negedge clk_ref);
        clr = 4'b0;
        chk("clr_alarm", alarm, 4'b1000);
        chk("clr_irq", irq, 1'b1);
        repeat (998) @(negedge clk_ref);
        clr = 4'b0010;
        @(negedge clk_ref);
        clr = 4'b0;
        chk("clr_publish_rv", rate_valid, 1'b1);
        chk("clr_publish_alarm", alarm, 4'b1010);

        for (int p = 0; p < 3; p++) begin
            locked[1] = 1'b0;
            repeat (4) @(negedge clk_ref);
            locked[1] = 1'b1;
            repeat (4) @(negedge clk_ref);
        end
        repeat (2) @(negedge clk_ref);
        chk("unlocks1_3", unlocks[31:16], 3);
        chk("unlocks0_0", unlocks[15:0], 0);
        locked[1] = 1'b0;
        repeat (3) @(negedge clk_ref);
        clr = 4'b0010;
        @(negedge clk_ref);
        clr = 4'b0;
        locked[1] = 1'b1;
        chk("unlocks1_clr_fall", unlocks[31:16], 1);
`ifdef CLK_FREQ_MON_LOCK_ALARM_EN
        exp_lock_alarm = 1'b1;
`else
        exp_lock_alarm = 1'b0;
`endif
        chk("lock_alarm1", alarm[1], exp_lock_alarm);
        chk("lock_alarm3", alarm[3], 1'b1);

        wait_rv(1100, n);
        saved = rate;
        repeat (500) @(negedge clk_ref);
        enable = 1'b0;
        rvc = 0;
        for (int c = 0; c < 1100; c++) begin
            @(negedge clk_ref);
            if (rate_valid) rvc++;
        end
        chk("abort_no_rv", rvc, 0);
        chk("abort_rate_held", rate === saved, 1'b1);
        chk("abort_idle", dut.state_q == IDLE, 1'b1);
        chk("abort_alarm_held", alarm, 4'b1010);
        enable = 1'b1;
        wait_rv(1100, n);
        chk("reenable_latency", n, 1001);

        repeat (300) @(negedge clk_ref);
        chk("pre_rst_alarm3", alarm[3], 1'b1);
        aresetn = 1'b0;
        #1;
        chk("midrst_alarm", alarm, 4'h0);
        chk("midrst_in_range", in_range, 4'hF);
        chk("midrst_rate", |rate, 1'b0);
        chk("midrst_irq", irq, 1'b0);
        chk("midrst_rv", rate_valid, 1'b0);
        window = 32'd0;
        @(negedge clk_ref);
        aresetn = 1'b1;
        exp_rv = 8'b0101_0100;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk_ref);
            chk($sformatf("win0_rv%0d", i), rate_valid, exp_rv[i-1]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/clk_freq_mon.md
CLK_FREQ_MON -- requirements
Module: clk_freq_mon

Interface
REQ-001 SHALL have parameter NCLK, default 4: number of monitored channels, 1..16.
REQ-002 SHALL have parameter CNT_W, default 32: edge-count and limit width.
REQ-003 SHALL have parameter WIN_W, default 32: window-length width.
REQ-004 SHALL have parameter UNL_W, default 16: unlock-counter width.
REQ-005 SHALL have ports, in order: clk_ref in 1, sole clock; aresetn in 1, async active-low reset.
REQ-006 clk_test in NCLK: monitored clocks, sampled as data in clk_ref domain.
REQ-007 locked in NCLK: asynchronous PLL lock flags.
REQ-008 enable in 1: run measurement windows.
REQ-009 window in WIN_W: window length in clk_ref cycles; values 0 and 1 are treated as 2.
REQ-010 min_cnt, max_cnt in NCLK*CNT_W: per-channel inclusive limits; channel i at [i*CNT_W +: CNT_W].
REQ-011 clr in NCLK: per-channel clear of alarm and unlock count.
REQ-012 rate out NCLK*CNT_W: last published edge count per channel.
REQ-013 rate_valid out 1: one-cycle publish strobe.
REQ-014 in_range out NCLK: last published rate lies within [min_cnt, max_cnt].
REQ-015 alarm out NCLK: sticky out-of-range flag.
REQ-016 unlocks out NCLK*UNL_W: saturating count of locked falling edges.
REQ-017 irq out 1: OR of all alarm bits.

Function
REQ-018 clk_test[i] and locked[i] SHALL each pass a 3-flop synchronizer; one rising edge SHALL be detected per sync 0->1 transition; requires f_test < f_ref/2.
REQ-019 Control FSM SHALL have states IDLE, MEASURE, PUBLISH.
REQ-020 IDLE: while enable=1, SHALL latch window (clamped to >=2) into the down-counter, zero all edge counters, and enter MEASURE next cycle.
REQ-021 MEASURE: SHALL decrement once per cycle and count detected edges; at count 1, SHALL enter PUBLISH.
REQ-022 PUBLISH, one cycle: rate<=edge count; rate_valid=1; in_range updated; edge counters reloaded to 0, or to 1 if an edge is detected this cycle; window re-latched; next state MEASURE if enable=1, else IDLE.
REQ-023 enable=0 during MEASURE SHALL abort to IDLE next cycle with no publish; rate, in_range, and alarm are held.
REQ-024 A change on the window input mid-window SHALL take effect only at the next latch.
REQ-025 Edge counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-026 In PUBLISH, alarm[i] SHALL be set when the count is < min_cnt[i] or > max_cnt[i] (unsigned compare).
REQ-027 alarm[i] SHALL clear only on clr[i]=1; simultaneous set and clr SHALL leave alarm set.
REQ-028 unlocks[i] SHALL increment on each synchronized locked[i] falling edge, saturating at 2^UNL_W-1.
REQ-029 clr[i] SHALL zero unlocks[i]; simultaneous clr and falling edge SHALL yield 1.
REQ-030 Latency: clk_test edge to edge-counter increment SHALL be 4 clk_ref cycles; rate_valid SHALL assert the cycle after the down-counter reaches 1.

Reset
REQ-031 aresetn=0 SHALL asynchronously force: FSM=IDLE; all synchronizers, counters, rate, unlocks and alarm to 0; in_range=1; rate_valid=0; irq=0.
REQ-032 Reset release SHALL be followed by normal operation; the first window SHALL start on the first cycle enable=1 is sampled.
REQ-033 Reset mid-window SHALL discard the partial window.

Configuration
REQ-034 With macro CLK_FREQ_MON_LOCK_ALARM_EN defined, a synchronized locked[i] falling edge SHALL also set alarm[i], subject to REQ-027 precedence.
REQ-035 Without CLK_FREQ_MON_LOCK_ALARM_EN, alarm[i] SHALL depend only on rate comparison; unlock counting SHALL be unchanged.

Structure
REQ-036 Package clk_freq_mon_pkg SHALL hold the FSM state enum (IDLE/MEASURE/PUBLISH), the window minimum constant 2, and default width constants.
REQ-037 Per-channel logic SHALL be sub-module clk_freq_chan, instantiated NCLK times by generate; the FSM and window counter SHALL be shared in clk_freq_mon.

Verification
REQ-038 f_ref=100 MHz, clk_test[0]=10 MHz, window=1000, enable=1 -> rate_valid every 1000 cycles; rate[0]=100 +/-1.
REQ-039 min_cnt=95, max_cnt=105, clk_test 20 MHz -> rate=200, in_range=0, alarm=1, irq=1; clr pulse -> alarm=0 unless the same cycle publishes out of range.
REQ-040 Three locked[1] pulses low, then clr[1] coincident with a fourth falling edge -> unlocks[1] reads 3, then 1; with CLK_FREQ_MON_LOCK_ALARM_EN, alarm[1]=1.
REQ-041 enable dropped at cycle 500 of a 1000-cycle window -> no rate_valid; FSM in IDLE; rate unchanged; re-enable -> full 1000-cycle window.
REQ-042 CNT_W=4, window=100, clk_test 25 MHz -> rate=15 (saturated).
REQ-043 aresetn asserted mid-window with alarm=1 -> alarm=0, in_range=1, rate=0 immediately; window=0 after reset -> rate_valid every 2 cycles.
